// File: rtl/sample_writer_pkg.sv
// sample_writer_pkg: shared state enum and default sizing for sample_writer
package sample_writer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  localparam int DEF_DEPTH  = 8192;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/sample_writer.sv
// sample_writer: streams accepted samples into a reservoir memory, one registered write per handshake
// Ports: clk, reset (async, active-high); start (begin new load at address 0);
//   s_data/s_valid/s_ready (sample stream in); wr_en/wr_addr/wr_data (memory write port);
//   count (words since start, saturating at DEPTH); busy (in LOAD); done (memory filled);
//   overflow (sticky, sample offered while FULL).
// Build option: define SAMPLE_WRITER_WRAP_EN for circular-buffer mode (address wraps, FULL unreachable).
module sample_writer
  import sample_writer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d, done_q, done_d, ovf_q, ovf_d;
  logic              hs, last;
  assign s_ready  = (state_q == LOAD) && !start;
  assign hs       = s_valid && s_ready;
  assign last     = addr_q == LAST;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign busy     = state_q == LOAD;
  assign done     = done_q;
  assign overflow = ovf_q;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    if (start) begin
      state_d = LOAD;
      addr_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (hs) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = s_data;
      addr_d    = last ? '0 : addr_q + 1'b1;
      count_d   = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
`ifdef SAMPLE_WRITER_WRAP_EN
      done_d    = done_q || last;
`else
      state_d   = last ? FULL : LOAD;
      done_d    = last;
`endif
    end else if (state_q == FULL && s_valid) begin
      ovf_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: doc/sample_writer.md
SAMPLE_WRITER -- requirements
Module: sample_writer

Interface
REQ-001 Parameter DEPTH, default 8192: number of words in the reservoir data memory.
REQ-002 Parameter ADDR_W, default 13: memory address width; DEPTH SHALL be at most 2^ADDR_W.
REQ-003 Parameter DATA_W, default 16: sample and memory word width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a new load at address 0.
REQ-007 s_data  in  DATA_W  incoming sample from the external source.
REQ-008 s_valid  in  1  s_data is valid this cycle.
REQ-009 s_ready  out  1  writer accepts a sample this cycle.
REQ-010 wr_en  out  1  memory write strobe, one cycle per word.
REQ-011 wr_addr  out  ADDR_W  memory write address.
REQ-012 wr_data  out  DATA_W  memory write data.
REQ-013 count  out  ADDR_W+1  words written since the last start, saturating at DEPTH.
REQ-014 busy  out  1  high in LOAD.
REQ-015 done  out  1  memory filled (level).
REQ-016 overflow  out  1  sticky: sample offered while the writer is in FULL.

Function
REQ-017 The FSM SHALL have three states: IDLE, LOAD and FULL.
REQ-018 On start in any state, the FSM SHALL enter LOAD and clear the address, count, done and overflow.
REQ-019 s_ready SHALL be combinationally high only in LOAD with start low.
REQ-020 A handshake (s_valid and s_ready) in cycle n SHALL produce wr_en=1, wr_addr=current address and wr_data=s_data in cycle n+1 (one registered stage).
REQ-021 wr_en SHALL be low in every cycle not following a handshake; wr_addr and wr_data SHALL hold their values when wr_en is low.
REQ-022 Each handshake SHALL increment the address by 1 and count by 1; count SHALL saturate at DEPTH.
REQ-023 If start and s_valid are both high in LOAD, start SHALL win and no write SHALL occur.
REQ-024 A handshake at address DEPTH-1 (wrap disabled) SHALL move the FSM to FULL and set done in the next cycle.
REQ-025 In IDLE and FULL, s_valid SHALL be ignored; s_valid high in FULL SHALL set overflow until the next start or reset.
REQ-026 busy SHALL equal (state == LOAD); done SHALL be high exactly while in FULL, or after the first wrap per REQ-031.

Reset
REQ-027 While reset is asserted, the FSM SHALL be in IDLE and all outputs SHALL be 0, including wr_en, wr_addr, wr_data, count, done and overflow.
REQ-028 Reset asserted during LOAD SHALL abandon the load immediately, with no further wr_en pulses.
REQ-029 After reset is released, the writer SHALL stay in IDLE until start.

Configuration
REQ-030 Macro SAMPLE_WRITER_WRAP_EN SHALL select circular-buffer mode.
REQ-031 With the macro defined, a handshake at address DEPTH-1 SHALL wrap the address to 0 and the FSM SHALL stay in LOAD; done SHALL set on the first wrap and hold until start or reset; FULL is unreachable and overflow stays 0.
REQ-032 Without the macro, the behaviour SHALL be as in REQ-024 and REQ-025.

Structure
REQ-033 A shared package sample_writer_pkg SHALL hold the state enumeration (IDLE, LOAD, FULL) and the default DEPTH, ADDR_W and DATA_W constants.
REQ-034 The design SHALL be a single module with no sub-module; the address/count counter and FSM SHALL be inline.

Verification (DEPTH=8)
REQ-035 Reset, then start, then 8 back-to-back valid samples 0x0001..0x0008 -> wr_en pulses at addresses 0..7 each one cycle after its handshake; done=1 and count=8 in the cycle after the 8th write; busy=0 thereafter.
REQ-036 In FULL, drive s_valid=1 with 0xBEEF -> s_ready=0, no wr_en, overflow=1 and held; a subsequent start clears overflow and done and sets count=0.
REQ-037 In LOAD, toggle s_valid every other cycle for 4 samples 0xA000..0xA003 -> exactly 4 writes at addresses 0..3 and count=4.
REQ-038 Assert start and s_valid together at address 5 -> no write occurs; the next handshake writes address 0.
REQ-039 Assert reset mid-load at address 3 -> all outputs are 0 immediately and no wr_en pulse occurs; after release the writer is in IDLE with s_ready=0.
REQ-040 With SAMPLE_WRITER_WRAP_EN defined, 10 samples -> the 9th write goes to address 0 and the 10th to address 1; done=1 from the first wrap; count=8 (saturated); busy stays 1.
